uart_tx_queue: RTL

//  Transmit-side buffer between the wishbone register block and the uart core.
//  - Accepts words from the bus side into a FIFO.
//  - Launches them one at a time into the uart: one-cycle tx-enable pulse plus a stable data word.
//  - Uses the uart tx-busy flag to pace launches.
//  - Lets software queue bursts without polling busy between words.

---
 rtl/uart_tx_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_queue.sv
// Transmit FIFO feeding the uart core; optional o_level port under `UART_TXQ_LEVEL_EN.
// Latency: a word written into an empty idle queue launches (o_tx_en) one cycle after the write edge.
// Backpressure: writes while full are dropped and latch o_overflow; launches pace on i_tx_busy or a timeout.
module uart_tx_queue #(
    parameter int G_WORD_WIDTH   = 8,
    parameter int G_DEPTH_LOG2   = 4,
    parameter int G_BUSY_TIMEOUT = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr,
    input  logic [G_WORD_WIDTH-1:0] i_wr_data,
    input  logic                    i_clr_ovf,
    input  logic                    i_tx_busy,
    output logic                    o_tx_en,
    output logic [G_WORD_WIDTH-1:0] o_tx_data,
    output logic                    o_full,
    output logic                    o_empty,
`ifdef UART_TXQ_LEVEL_EN
    output logic [G_DEPTH_LOG2:0]   o_level,
`endif
    output logic                    o_overflow
);

    localparam int DEPTH = 2 ** G_DEPTH_LOG2;
    localparam int TW    = $clog2(G_BUSY_TIMEOUT + 1);
    localparam logic [G_DEPTH_LOG2:0] FULL_CNT = (G_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TW-1:0]         TO_LAST  = TW'(G_BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [G_WORD_WIDTH-1:0]   mem [DEPTH];
    logic [G_DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [G_DEPTH_LOG2:0]     count, count_nxt;
    logic [TW-1:0]             tmo_cnt;
    logic                      push, pop;

    // Full is judged on the registered flag, so a write into a full queue is dropped even if a pop frees a slot.
    assign push = i_wr && !o_full;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH:    state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (i_tx_busy)
                    state_nxt = S_WAIT_DONE;
                else if (tmo_cnt == TO_LAST)
                    state_nxt = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy)
                    state_nxt = S_IDLE;
            end
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_full     <= 1'b0;
            o_empty    <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            o_full  <= (count_nxt == FULL_CNT);
            o_empty <= (count_nxt == '0);
            if (i_wr && o_full)
                o_overflow <= 1'b1;
            else if (i_clr_ovf)
                o_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            o_tx_en   <= 1'b0;
            o_tx_data <= '0;
        end else begin
            state   <= state_nxt;
            o_tx_en <= pop;
            if (pop)
                o_tx_data <= mem[rd_ptr];
            // A launch with no busy response is treated as sent once the timeout window closes.
            if (state == S_LAUNCH)
                tmo_cnt <= '0;
            else if (state == S_WAIT_BUSY && !i_tx_busy && tmo_cnt != TO_LAST)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

`ifdef UART_TXQ_LEVEL_EN
    assign o_level = count;
`endif

endmodule
